// File: rtl/mmio_pkg.sv
// Definitions shared by the memory stage and the MMIO UART transmitter.
// Holds the bus width, the I/O address map and the UART frame geometry.
package mmio_pkg;
  localparam int BUS_WIDTH          = 32;
  localparam int MEM_MAP_IO_ADDRESS = 128;
  localparam int BITS_PER_BYTE      = 8;
  localparam int BYTES_PER_WORD     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// Store-path push port and serial-side status of the MMIO UART transmitter.
// The master drives pushes; the slave (the UART) returns tx and FIFO status.
interface mmio_uart_tx_if;
  import mmio_pkg::*;

  logic                 io_wr;
  logic [BUS_WIDTH-1:0] io_data;
  logic                 tx;
  logic                 busy;
  logic                 full;
  logic                 overflow;

  modport master (output io_wr, io_data, input tx, busy, full, overflow);
  modport slave  (input io_wr, io_data, output tx, busy, full, overflow);
endinterface

// File: rtl/mmio_fifo.sv
// Synchronous FIFO, combinational read of the head word, one-cycle write.
// A push while full is only accepted when a pop happens on the same edge.
module mmio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Serialises each stored 32-bit word as four 8N1 bytes, LSB byte first; tx falls one edge after a push.
// No backpressure: pushes into a full FIFO (without a same-edge pop) are dropped and flag overflow.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  mmio_uart_tx_if.slave bus
);
  localparam int             TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  T_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  uart_state_t          state, state_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [1:0]           byte_idx, byte_idx_nxt;
  logic [BUS_WIDTH-1:0] shreg, shreg_nxt;
  logic                 tx_q, tx_nxt;
  logic                 ovf_q, ovf_nxt;
  logic                 pop;
  logic                 tick;
  logic [7:0]           cur_byte;
  logic [BUS_WIDTH-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  mmio_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.io_wr),
    .pop   (pop),
    .din   (bus.io_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick     = (timer == '0);
  assign cur_byte = shreg[7:0];

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    shreg_nxt    = shreg;
    tx_nxt       = tx_q;
    pop          = 1'b0;
    if (state != IDLE && !tick) timer_nxt = timer - 1'b1;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_nxt    = fifo_dout;
          byte_idx_nxt = '0;
          bit_idx_nxt  = '0;
          timer_nxt    = T_LOAD;
          tx_nxt       = 1'b0;
          state_nxt    = START;
        end
      end
      START: begin
        if (tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = cur_byte[0];
          timer_nxt   = T_LOAD;
        end
      end
      DATA: begin
        if (tick) begin
          timer_nxt = T_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = cur_byte[bit_idx_nxt];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx != LAST_BYTE) begin
            byte_idx_nxt = byte_idx + 1'b1;
            shreg_nxt    = shreg >> BITS_PER_BYTE;
            timer_nxt    = T_LOAD;
            tx_nxt       = 1'b0;
            state_nxt    = START;
          end else if (!fifo_empty) begin
            // Next word starts straight after this stop bit, no idle gap.
            pop          = 1'b1;
            shreg_nxt    = fifo_dout;
            byte_idx_nxt = '0;
            timer_nxt    = T_LOAD;
            tx_nxt       = 1'b0;
            state_nxt    = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    ovf_nxt = ovf_q | (bus.io_wr & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      shreg    <= shreg_nxt;
      tx_q     <= tx_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE) || !fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed vector table, line-decoding sequences and
// random pushes checked every cycle against a word-level timing model.
module tb_mmio_uart_tx;
  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int WORD_CYC = 4 * BYTE_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Word-level model: queue of buffered words plus the word on the line and
  // how many cycles of its 40*CPB-cycle frame have elapsed.
  logic [31:0] mq[$];
  logic [31:0] m_cur;
  bit          m_active;
  int          m_pos;
  bit          m_ovf;

  bit rec;
  bit line[$];

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] data;
    bit          tx;
    bit          busy;
    bit          full;
    bit          ovf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = (m_pos % BYTE_CYC) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[8 * (m_pos / BYTE_CYC) + slot - 1];
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] d);
    bit pop, acc;
    if (r) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
      return;
    end
    pop = (mq.size() > 0) && (!m_active || m_pos == WORD_CYC - 1);
    acc = w && (mq.size() < DEPTH || pop);
    if (w && !acc) m_ovf = 1;
    if (pop) begin
      m_cur    = mq.pop_front();
      m_active = 1;
      m_pos    = 0;
    end else if (m_active) begin
      if (m_pos == WORD_CYC - 1) m_active = 0;
      else m_pos++;
    end
    if (acc) mq.push_back(d);
  endtask

  task automatic step(input bit r, input bit w, input logic [31:0] d);
    rst         = r;
    bus.io_wr   = w;
    bus.io_data = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    cyc++;
    if (rec) line.push_back(bus.tx);
    chk("model_tx",   bus.tx,       m_tx());
    chk("model_busy", bus.busy,     m_active || mq.size() > 0);
    chk("model_full", bus.full,     mq.size() == DEPTH);
    chk("model_ovf",  bus.overflow, m_ovf);
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    do begin
      step(0, 0, 32'h0);
      n++;
    end while (bus.busy && n < bound);
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  function automatic bit line_at(input int k);
    if (k < 0 || k >= line.size()) return 1'b0;
    return line[k];
  endfunction

  // Decodes bytes from the recorded line by sampling mid-bit and compares them
  // against the pushed words, LSB byte first.
  task automatic send_and_check(input logic [31:0] w0, input logic [31:0] w1, input int n);
    int fall = -1;
    line.delete();
    rec = 1;
    step(0, 1, w0);
    if (n == 2) step(0, 1, w1);
    run_until_idle(n * WORD_CYC + 20);
    rec = 0;
    for (int k = 0; k < line.size(); k++)
      if (fall < 0 && !line[k]) fall = k;
    chk("latency", fall, 1);
    chk("word_time", line.size() - 1 - fall, n * WORD_CYC);
    for (int g = 0; g < 4 * n; g++) begin
      int          base = fall + BYTE_CYC * g;
      logic [31:0] w    = (g < 4) ? w0 : w1;
      logic [7:0]  got;
      for (int i = 0; i < 8; i++) got[i] = line_at(base + CPB * (i + 1) + CPB / 2);
      chk("frame", {line_at(base + CPB / 2), line_at(base + 9 * CPB + CPB / 2)}, 2'b01);
      chk("byte", got, w[8 * (g % 4) +: 8]);
    end
  endtask

  initial begin
    bus.io_wr   = 1'b0;
    bus.io_data = 32'h0;
    rec         = 0;

    tbl[0] = '{1, 0, 32'h0,  1, 0, 0, 0};
    tbl[1] = '{1, 1, 32'h41, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 32'h41, 1, 1, 0, 0};
    for (int i = 3; i <= 6; i++)  tbl[i] = '{0, 0, 32'h0, 0, 1, 0, 0};
    for (int i = 7; i <= 10; i++) tbl[i] = '{0, 0, 32'h0, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 32'h0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 32'h0, 0, 1, 0, 0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].data);
      chk($sformatf("vec%0d_tx", i),   bus.tx,       tbl[i].tx);
      chk($sformatf("vec%0d_busy", i), bus.busy,     tbl[i].busy);
      chk($sformatf("vec%0d_full", i), bus.full,     tbl[i].full);
      chk($sformatf("vec%0d_ovf", i),  bus.overflow, tbl[i].ovf);
    end
    run_until_idle(WORD_CYC + 20);

    send_and_check(32'h0000_0041, 32'h0, 1);
    send_and_check(32'hDEAD_BEEF, 32'h0, 1);
    send_and_check(32'h1122_3344, 32'h5566_7788, 2);

    // Overflow: one word in flight, four buffered, sixth dropped.
    begin
      int fall = -1;
      line.delete();
      rec = 1;
      for (int i = 0; i < 6; i++) begin
        step(0, 1, $urandom);
        if (i == 4) chk("ovf_full_after5", bus.full, 1'b1);
        if (i == 5) chk("ovf_set", bus.overflow, 1'b1);
      end
      run_until_idle(6 * WORD_CYC);
      rec = 0;
      for (int k = 0; k < line.size(); k++)
        if (fall < 0 && !line[k]) fall = k;
      chk("ovf_five_words", line.size() - 1 - fall, 5 * WORD_CYC);
      chk("ovf_sticky", bus.overflow, 1'b1);
      step(1, 0, 32'h0);
      chk("ovf_cleared", bus.overflow, 1'b0);
      step(0, 0, 32'h0);
    end

    // Push on the edge that pops the next word while the FIFO is full.
    for (int i = 0; i < 5; i++) step(0, 1, $urandom);
    chk("pap_full", bus.full, 1'b1);
    for (int k = 0; k < 2 * WORD_CYC && !(m_active && m_pos == WORD_CYC - 1); k++)
      step(0, 0, 32'h0);
    step(0, 1, 32'hCAFE_F00D);
    chk("pap_no_ovf", bus.overflow, 1'b0);
    chk("pap_still_full", bus.full, 1'b1);
    run_until_idle(6 * WORD_CYC);
    chk("pap_no_ovf_end", bus.overflow, 1'b0);

    // Reset in the middle of a data bit.
    step(0, 1, 32'hA5A5_A5A5);
    for (int k = 0; k < 40 && !(m_active && m_pos == 3 * CPB); k++) step(0, 1, $urandom);
    step(1, 0, 32'h0);
    chk("rst_mid_tx", bus.tx, 1'b1);
    chk("rst_mid_busy", bus.busy, 1'b0);
    step(0, 0, 32'h0);

    for (int seg = 0; seg < 6; seg++) begin
      int rate = (seg % 3 == 0) ? 300 : (seg % 3 == 1) ? 60 : 4;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(999) == 0) step(1, 0, 32'h0);
        else step(0, $urandom_range(rate - 1) == 0, $urandom);
      end
    end
    run_until_idle(6 * WORD_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Consumer of the memory-mapped I/O store path, sitting directly downstream of the data-memory stage.
- Each store to I/O address 128 pushes one 32-bit word into a small FIFO. The block then serializes the word as four 8N1 UART bytes, least-significant byte first, on a single tx pin.
- This gives the multi-cycle core a console output that needs no polling for short bursts.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, number of 32-bit words buffered; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset.
- io_wr  in  1  push strobe: one word per cycle asserted. Top level drives it as (address == 128) && wr_en, one cycle per store.
- io_data  in  32  word to transmit; sampled with io_wr.
- tx  out  1  serial line; idle high.
- busy  out  1  high while (state != IDLE) || FIFO not empty.
- full  out  1  FIFO holds FIFO_DEPTH words.
- overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset: rst is synchronous and active-high, and dominates all other inputs.
  - After the reset edge: tx=1, busy=0, full=0, overflow=0.
  - FIFO is empty; state=IDLE; bit timer, bit index and byte index are all 0.
  - Reset mid-frame aborts the frame, so tx returns high on that edge. Buffered words are discarded.
- Push:
  - A push occurs on an edge where io_wr=1 and the FIFO is not full, OR where the FIFO is full and a pop happens on the same edge.
  - io_wr=1 with the FIFO full and no pop: the word is dropped and overflow is set to 1. It stays 1 until rst.
- Pop: occurs only when the FSM loads a new word (IDLE->START, or STOP of byte 3 -> START).
- Simultaneous push and pop: occupancy count is unchanged.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. A separate count is kept, 0..FIFO_DEPTH.
- FSM states, with tx registered:
  - IDLE: tx=1. If the FIFO is not empty: pop, load the word into the shift register, set byte_idx=0, go to START, and set tx<=0 on the same edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0 and tx<=bit0 of the current byte.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP with tx<=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte_idx<3: increment byte_idx, shift the word right by 8, go to START.
    - byte_idx==3 and FIFO not empty: pop, go to START (back-to-back, no idle bit).
    - otherwise: go to IDLE.
- Bit timer:
  - Loads CLKS_PER_BIT-1 on every state/bit transition and decrements to 0.
  - A transition fires on the edge where the timer is 0.
  - Width is clog2(CLKS_PER_BIT).
- Latency: with io_wr sampled at edge N into an empty, idle block, tx goes low after edge N+1.
- One word occupies exactly 40*CLKS_PER_BIT cycles on the line.
- busy and full are combinational from state and count. overflow is registered.
- io_data is not required to be held after the push edge.

Decomposition:
- Shared package (mmio_pkg):
  - BUS_WIDTH=32 and MEM_MAP_IO_ADDRESS=128, reused by the memory stage.
  - UART state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - BITS_PER_BYTE=8 and BYTES_PER_WORD=4.
- Sub-module mmio_fifo: synchronous FIFO, parameterised width/depth.
  - Ports: push, pop, din, dout, full, empty.
  - Same rst semantics; push-when-full-with-pop accepted.
- The FSM and shift register stay in mmio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold rst 2 cycles -> tx=1, busy=0, full=0, overflow=0. Assert rst mid-DATA -> tx=1 on the next edge and busy=0.
- Single word: io_wr=1 for 1 cycle, io_data=32'h0000_0041 -> tx low after second edge.
  - Decoded bytes are 0x41, 0x00, 0x00, 0x00, each framed by start=0 and stop=1.
  - busy falls exactly 160 cycles after tx first falls.
- Byte order: io_data=32'hDEAD_BEEF -> bytes EF, BE, AD, DE in that order.
- Back-to-back: push 32'h11223344 and 32'h55667788 on consecutive cycles.
  - Line carries 8 bytes with no idle gap: 44 33 22 11 88 77 66 55.
  - Total time is 320 cycles.
- Overflow: push 6 words on consecutive cycles while the first is loading.
  - 1 word in flight + 4 buffered; full=1 after the 5th push.
  - 6th push dropped, overflow=1; exactly 5 words transmitted; overflow stays 1 until rst.
- Push-at-pop while full: FIFO full; io_wr coincides with STOP of byte 3 -> word accepted, overflow stays 0, full remains 1.
